rtm_d2c: RTL
============

Name: rtm_d2c

Overview:
- Loads a tensor from DRAM into RTM (DRAM-to-chip direction). It is the mirror stage of the RTM write-back path.
- Issues one DMA read descriptor and accepts the DMA read AXI-Stream.
- Packs N = S*R*8/DDR_AXIS_DATA_WIDTH consecutive stream beats into one RTM word and writes that word to all S RTM banks at consecutive addresses starting from c_addr.
- Sits between the DMA read controller and the RTM write ports; the instruction decoder drives it.

Parameters:
- DDR_AXIS_DATA_WIDTH, 512, DMA read stream data width in bits.
- DDR_AXI_ADDR_WIDTH, 32, DRAM byte-address width.
- DDR_LEN_WIDTH, 32, DMA descriptor length width.
- S, 8, number of RTM banks.
- R, 16, bytes per bank per RTM word.
- RTM_DEPTH, 4096, words per bank; AW = clog2(RTM_DEPTH).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start_pulse  in  1  one-cycle start command.
- d_addr  in  32  DRAM source byte address.
- c_addr  in  32  RTM start word address; low AW bits used.
- n_bytes  in  32  transfer size in bytes; must be a multiple of R*S and nonzero.
- done_pulse  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted start until done_pulse.
- dma_rd_desc_addr  out  DDR_AXI_ADDR_WIDTH  descriptor address.
- dma_rd_desc_len  out  DDR_LEN_WIDTH  descriptor length.
- dma_rd_desc_valid  out  1  one-cycle descriptor strobe.
- dma_rd_desc_status_valid  in  1  DMA completion status.
- dma_rd_read_data_tdata  in  DDR_AXIS_DATA_WIDTH  stream data.
- dma_rd_read_data_tvalid  in  1  stream valid.
- dma_rd_read_data_tready  out  1  stream ready.
- dma_rd_read_data_tlast  in  1  stream last beat.
- rtm_wr_vld  out  1  write-word strobe.
- rtm_wr_en  out  S  per-bank write enables.
- rtm_wr_addr  out  S*AW  per-bank word address; all slices equal.
- rtm_din  out  S*R*8  packed write data.

Behaviour:
- Reset: every output is 0, the FSM is IDLE, all counters are cleared. A reset mid-transfer aborts immediately, with no done_pulse and no further RTM writes; stream beats that arrive afterwards are not accepted (tready=0).
- FSM states: IDLE, REQ, XFER, DRAIN.
- IDLE:
  - start_pulse latches d_addr, c_addr[AW-1:0], n_bytes and moves to REQ.
  - start_pulse while not IDLE is ignored.
- REQ (exactly one cycle):
  - dma_rd_desc_valid=1, desc_addr=d_addr, desc_len=n_bytes.
  - Loads total_words = n_bytes[31:clog2(R*S)] and clears word_cnt, lane and sts_seen. Next state is XFER.
  - Latency: desc_valid rises 2 cycles after start_pulse.
- XFER:
  - tready=1 continuously; the RTM has no backpressure.
  - Each accepted beat (tvalid&&tready) is stored into lane `lane`, at bits [lane*DW +: DW] of the pack register. Beat 0 goes to the LSBs.
  - lane counts 0..N-1 and wraps. When N=1, every beat completes a word.
  - When a beat completes a word, on the next cycle: rtm_wr_vld=1, rtm_wr_en=all ones, rtm_wr_addr=next_addr in every slice, rtm_din=the packed word. The next cycle also increments next_addr (mod RTM_DEPTH, wrapping silently) and word_cnt.
  - Write latency: 1 cycle after the completing beat.
  - The beat with tlast=1 ends XFER and moves to DRAIN.
  - If tlast arrives with lane != N-1, the partial word is still written; unfilled lanes are 0.
  - Beats received after word_cnt reaches total_words are accepted and dropped (no write).
- DRAIN: waits until the final RTM write has issued and sts_seen=1, then emits done_pulse for one cycle and returns to IDLE.
- dma_rd_desc_status_valid sets sts_seen in any non-IDLE state. It may arrive before, with, or after tlast; all three orderings produce exactly one done_pulse.
- busy = (state != IDLE).

Test Plan:
- Defaults (N=2): start with d_addr=0x1000, c_addr=5, n_bytes=384 -> desc 0x1000/384 two cycles after start. Six beats produce 3 writes to addresses 5, 6, 7, each rtm_din = {beat1,beat0}. One done_pulse after status.
- tvalid toggling every other cycle for the same 6 beats -> identical writes and addresses; no spurious rtm_wr_vld.
- c_addr=4095, n_bytes=256 -> writes to addresses 4095 then 0.
- dma_rd_desc_status_valid asserted 3 cycles before tlast -> done_pulse only after the final write, exactly once.
- Second start_pulse mid-transfer -> ignored; rst asserted after the 2nd beat -> all outputs 0 next cycle and no done_pulse. A fresh start afterwards runs correctly.
- tlast on beat 3 with n_bytes=256 -> second word written with upper lane 0, then done.

Source files
------------

// File: rtl/rtm_d2c.sv
// rtm_d2c: loads a tensor from DRAM into the RTM (DRAM-to-chip direction).
//
// Issues a single DMA read descriptor, accepts the DMA read AXI-Stream,
// packs N = S*R*8/DDR_AXIS_DATA_WIDTH consecutive beats into one RTM word
// (beat 0 in the LSBs) and writes each word to all S banks at consecutive
// word addresses starting at c_addr.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_pulse
// REQ    | one cycle: load counters, strobe the read descriptor
// XFER   | accepting stream beats, packing and writing RTM words
// DRAIN  | tlast seen; waiting for DMA status before done_pulse
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start_pulse, d_addr,
//   c_addr, n_bytes              command from the instruction decoder
//   done_pulse, busy             command status
//   dma_rd_desc_*                DMA read descriptor / completion status
//   dma_rd_read_data_*           DMA read AXI-Stream
//   rtm_wr_vld, rtm_wr_en,
//   rtm_wr_addr, rtm_din         RTM write port (all banks written together)

module rtm_d2c #(
    parameter int DDR_AXIS_DATA_WIDTH = 512,
    parameter int DDR_AXI_ADDR_WIDTH  = 32,
    parameter int DDR_LEN_WIDTH       = 32,
    parameter int S                   = 8,
    parameter int R                   = 16,
    parameter int RTM_DEPTH           = 4096,
    localparam int AW                 = $clog2(RTM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_pulse,
    input  logic [31:0]                    d_addr,
    input  logic [31:0]                    c_addr,
    input  logic [31:0]                    n_bytes,
    output logic                           done_pulse,
    output logic                           busy,
    output logic [DDR_AXI_ADDR_WIDTH-1:0]  dma_rd_desc_addr,
    output logic [DDR_LEN_WIDTH-1:0]       dma_rd_desc_len,
    output logic                           dma_rd_desc_valid,
    input  logic                           dma_rd_desc_status_valid,
    input  logic [DDR_AXIS_DATA_WIDTH-1:0] dma_rd_read_data_tdata,
    input  logic                           dma_rd_read_data_tvalid,
    output logic                           dma_rd_read_data_tready,
    input  logic                           dma_rd_read_data_tlast,
    output logic                           rtm_wr_vld,
    output logic [S-1:0]                   rtm_wr_en,
    output logic [S*AW-1:0]                rtm_wr_addr,
    output logic [S*R*8-1:0]               rtm_din
);

    localparam int DW    = DDR_AXIS_DATA_WIDTH;
    localparam int WW    = S * R * 8;
    localparam int N     = WW / DW;
    localparam int LW    = (N > 1) ? $clog2(N) : 1;
    localparam int RS_LG = $clog2(R * S);
    localparam int TW    = 32 - RS_LG;

    typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

    state_t state, state_nxt;

    logic [31:0]                   d_addr_r;
    logic [31:0]                   n_bytes_r;
    logic [AW-1:0]                 next_addr;
    logic [TW-1:0]                 total_words;
    logic [TW-1:0]                 word_cnt;
    logic [LW-1:0]                 lane;
    logic                          sts_seen;
    logic [WW-1:0]                 pack;
    logic [WW-1:0]                 pack_nxt;

    logic                          desc_valid_r;
    logic [DDR_AXI_ADDR_WIDTH-1:0] desc_addr_r;
    logic [DDR_LEN_WIDTH-1:0]      desc_len_r;
    logic                          wr_vld_r;
    logic [S-1:0]                  wr_en_r;
    logic [AW-1:0]                 wr_addr_r;
    logic [WW-1:0]                 din_r;
    logic                          done_r;

    logic                          beat_acc;
    logic                          beat_cmpl;
    logic                          wr_issue;
    logic                          unused_bits;

    assign unused_bits = ^c_addr[31:AW];

    assign beat_acc  = (state == XFER) && dma_rd_read_data_tvalid;
    // A word completes on the last lane, or early on tlast (partial word).
    assign beat_cmpl = beat_acc && (dma_rd_read_data_tlast || (lane == LW'(N - 1)));
    // Words beyond the requested size are accepted from the stream but dropped.
    assign wr_issue  = beat_cmpl && (word_cnt < total_words);

    always_comb begin
        pack_nxt = pack;
        pack_nxt[lane*DW +: DW] = dma_rd_read_data_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final write is registered on the tlast edge, so by the time DRAIN
    // is entered it has already issued; only the DMA status is awaited.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_pulse) state_nxt = REQ;
            REQ:     state_nxt = XFER;
            XFER:    if (beat_acc && dma_rd_read_data_tlast) state_nxt = DRAIN;
            DRAIN:   if (sts_seen || dma_rd_desc_status_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_addr_r     <= '0;
            n_bytes_r    <= '0;
            next_addr    <= '0;
            total_words  <= '0;
            word_cnt     <= '0;
            lane         <= '0;
            sts_seen     <= 1'b0;
            pack         <= '0;
            desc_valid_r <= 1'b0;
            desc_addr_r  <= '0;
            desc_len_r   <= '0;
            wr_vld_r     <= 1'b0;
            wr_en_r      <= '0;
            wr_addr_r    <= '0;
            din_r        <= '0;
            done_r       <= 1'b0;
        end else begin
            desc_valid_r <= 1'b0;
            wr_vld_r     <= 1'b0;
            wr_en_r      <= '0;
            done_r       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        d_addr_r  <= d_addr;
                        next_addr <= c_addr[AW-1:0];
                        n_bytes_r <= n_bytes;
                    end
                end
                REQ: begin
                    desc_valid_r <= 1'b1;
                    desc_addr_r  <= DDR_AXI_ADDR_WIDTH'(d_addr_r);
                    desc_len_r   <= DDR_LEN_WIDTH'(n_bytes_r);
                    total_words  <= n_bytes_r[31:RS_LG];
                    word_cnt     <= '0;
                    lane         <= '0;
                    pack         <= '0;
                    sts_seen     <= dma_rd_desc_status_valid;
                end
                XFER: begin
                    if (dma_rd_desc_status_valid) sts_seen <= 1'b1;
                    if (beat_acc) begin
                        if (beat_cmpl) begin
                            lane <= '0;
                            pack <= '0;
                            if (wr_issue) begin
                                wr_vld_r  <= 1'b1;
                                wr_en_r   <= '1;
                                wr_addr_r <= next_addr;
                                din_r     <= pack_nxt;
                                next_addr <= next_addr + 1'b1;
                                word_cnt  <= word_cnt + 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                            pack <= pack_nxt;
                        end
                    end
                end
                DRAIN: begin
                    if (dma_rd_desc_status_valid) sts_seen <= 1'b1;
                    if (state_nxt == IDLE) done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy                    = (state != IDLE);
    assign done_pulse              = done_r;
    assign dma_rd_desc_valid       = desc_valid_r;
    assign dma_rd_desc_addr        = desc_addr_r;
    assign dma_rd_desc_len         = desc_len_r;
    assign dma_rd_read_data_tready = (state == XFER);
    assign rtm_wr_vld              = wr_vld_r;
    assign rtm_wr_en               = wr_en_r;
    assign rtm_wr_addr             = {S{wr_addr_r}};
    assign rtm_din                 = din_r;

endmodule
